fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Small FIFO of fetched {pc, instruction} pairs between the instruction-fetch datapath (PC, PC+4 adder, instruction memory) and the instruction decoder.
- Decouples fetch from decode stalls.
- Flushes all queued instructions when a branch redirects the PC (BrTaken or BR-register path).
- Fetch pushes; decode pops, with valid/ready handshakes on both sides.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
ADDR_W, 64, PC width
INSTR_W, 32, instruction width

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset)
flush  input  1  discard all entries (branch redirect)
in_valid  input  1  fetch presents a valid pc/instruction
in_ready  output  1  queue can accept a push this cycle
in_pc  input  ADDR_W  PC of fetched instruction
in_instr  input  INSTR_W  fetched instruction word
out_valid  output  1  head entry valid
out_ready  input  1  decode accepts head this cycle
out_pc  output  ADDR_W  PC of head entry
out_instr  output  INSTR_W  head instruction word
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, asynchronous, applied at any time including mid-operation):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, in_ready=1, out_pc=0, out_instr=NOP_INSTR.
  - Storage contents are don't-care.
  - Reset dominates flush and all handshakes.
- Push fires when in_valid && in_ready at a rising edge:
  - Entry is written at wr_ptr.
  - wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Pop fires when out_valid && out_ready at a rising edge:
  - rd_ptr increments modulo DEPTH.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Both: unchanged.
  - Neither: unchanged.
- in_ready = (count != DEPTH).
  - Registered-state function only; no combinational path from out_ready to in_ready.
  - A full queue therefore refuses a push even when a pop happens in the same cycle.
- out_valid = (count != 0).
- First-word-fall-through:
  - out_pc/out_instr show entry[rd_ptr] combinationally from storage.
  - When count=0 they show 0 / NOP_INSTR.
- Latency:
  - A push into an empty queue appears on out_* in the next cycle.
  - There is no same-cycle bypass from in_* to out_*.
- Flush has priority over push and pop in the same cycle:
  - Next state is wr_ptr=rd_ptr=0, count=0.
  - A push or pop presented in the flush cycle is discarded with no effect.
  - in_ready stays 1 after a flush.
- Pop is ignored when empty; out_valid=0 prevents it by protocol.
- Push is ignored when full; in_ready=0 prevents it by protocol.
- Producer-side rule (decided): in_pc/in_instr are sampled only in the cycle the push fires. Fetch must hold the PC (i.e. not advance the program counter) while in_valid && !in_ready.
- FIFO order is preserved: entries leave in push order.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W=64, INSTR_W=32.
  - NOP_INSTR = 32'hD503201F (ARMv8 NOP).
  - Packed struct fetch_entry_t {pc, instr}.
- One sub-module, fetch_queue_mem:
  - DEPTH x fetch_entry_t register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset on the storage.
- Top level holds pointers, count, flush and handshake logic.

Test Plan:
1. Reset then 3 pushes (pc 0x0/0x4/0x8, instr 0x91000421/0x8B020020/0xB4000040), out_ready=0 -> count=3, out_valid=1, out_pc=0x0, out_instr=0x91000421, in_ready=1.
2. Push 4 entries with out_ready=0 -> count=4, in_ready=0. A 5th push (pc 0x10) is dropped. Then pop 4 cycles -> out_pc sequence 0x0,0x4,0x8,0xC, then out_valid=0, out_instr=NOP_INSTR.
3. Steady state with count=2: push and pop together for 10 cycles with pc stepping +4 -> count stays 2, out_pc always trails in_pc by 8. Pointers wrap past 3 with no loss or reordering.
4. Queue full, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1. A push at pc 0x100 on the following cycle appears at out_pc=0x100 one cycle later.
5. Full queue with out_ready=1 and in_valid=1 in the same cycle -> pop occurs, push is refused, count=3 afterward.
6. Drive reset=0 asynchronously between clock edges with count=2 -> count=0, out_valid=0, in_ready=1 immediately, before the next edge. Release reset, then one push -> out_valid=1 after one edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the architectural NOP and the
// fetch entry record carried from the fetch stage to the decoder.
package cpu_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  // ARMv8 NOP, shown on the decoder side whenever nothing is queued
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_queue_mem.sv
// Storage array for the fetch queue: one synchronous write port and one
// asynchronous read port, so the head entry is visible without a cycle of
// read latency. Contents are deliberately left unreset.
module fetch_queue_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_entry_t             rdata
);

  fetch_entry_t mem [DEPTH];

  // Capture the pushed entry at its slot on the clock edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// Fetch queue: a small first-word-fall-through FIFO of {pc, instr} pairs
// between instruction fetch and decode. Holds the pointers, occupancy count,
// handshake and flush logic; storage lives in fetch_queue_mem.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_pc,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [$clog2(DEPTH):0] count
);

  import cpu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;
  logic             write_en;
  fetch_entry_t     wdata;
  fetch_entry_t     rdata;

  // Readiness depends only on registered occupancy, so a full queue refuses
  // a push even when the decoder pops in the same cycle.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign write_en  = push && !flush;
  assign count     = count_q;

  assign wdata.pc    = in_pc;
  assign wdata.instr = in_instr;

  fetch_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (write_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Pointer and occupancy update; a flush discards the whole queue and any
  // handshake presented with it. Pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Head entry falls straight through from storage; an empty queue shows
  // a zero PC and a NOP so the decoder never sees stale storage.
  always_comb begin
    out_pc    = '0;
    out_instr = NOP_INSTR;
    if (out_valid) begin
      out_pc    = rdata.pc;
      out_instr = rdata.instr;
    end
  end

endmodule : fetch_queue
